cla_seq_adder: RTL and testbench

- Multi-cycle wide adder/subtractor built around one shared 16-bit carry-lookahead slice (CLA_16bit).
- Splits WIDTH-bit operands into 16-bit chunks, LSB chunk first, and feeds them through the slice one chunk per cycle.
- Chunk carry-out is registered and used as the next chunk's carry-in.
- Valid/ready handshake on input and output; sits between the operand-issue stage and the result writeback.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_seq_adder_cla16.sv | 42 ++++
 rtl/cla_seq_adder.sv | 110 +++++++++++
 tb/tb_cla_seq_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the chunked carry-lookahead adder: slice width,
// FSM state encoding and the chunk-index width helper.
package cla_pkg;

   localparam int CHUNK_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Index register width; a single-chunk adder still gets a 1-bit index.
   function automatic int idx_w(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage

// File: rtl/cla_seq_adder_cla16.sv
// 16-bit carry-lookahead slice: four 4-bit groups with group generate/propagate
// and a second lookahead level across the groups.
module CLA_16bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);

   logic [15:0] g, p, c;
   logic [3:0]  gg, pg;
   logic [4:0]  gc;

   always_comb begin
      g = a_i & b_i;
      p = a_i ^ b_i;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+3 -: 2] & g[4*j+1])
               | (&p[4*j+3 -: 3] & g[4*j]);
         pg[j] = &p[4*j +: 4];
      end
      gc[0] = c_i;
      gc[1] = gg[0] | (pg[0] & c_i);
      gc[2] = gg[1] | (pg[1] & gg[0]) | (&pg[1:0] & c_i);
      gc[3] = gg[2] | (pg[2] & gg[1]) | (&pg[2:1] & gg[0]) | (&pg[2:0] & c_i);
      gc[4] = gg[3] | (pg[3] & gg[2]) | (&pg[3:2] & gg[1]) | (&pg[3:1] & gg[0])
            | (&pg & c_i);
      // Bit carries inside each group look ahead from the group carry-in.
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (&p[4*j+1 -: 2] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (&p[4*j+2 -: 2] & g[4*j])
                  | (&p[4*j+2 -: 3] & gc[j]);
      end
   end

   assign s_o = p ^ c;
   assign c_o = gc[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one shared 16-bit CLA slice processes
// one chunk per cycle, LSB first, with the chunk carry held in a register.
module cla_seq_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_carry,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK_W;
   localparam int IW     = idx_w(NCHUNK);

   state_e                             state_q, state_d;
   logic [IW-1:0]                      idx_q, idx_d;
   logic [NCHUNK-1:0][CHUNK_W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                               carry_q, carry_d;
   logic                               cout_q, cout_d, ovf_q, ovf_d;
   logic [CHUNK_W-1:0]                 slice_s;
   logic                               slice_c;
   logic                               last;

   CLA_16bit u_slice (
      .a_i (a_q[idx_q]),
      .b_i (b_q[idx_q]),
      .c_i (carry_q),
      .s_o (slice_s),
      .c_o (slice_c)
   );

   assign last = (idx_q == IW'(NCHUNK - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            // Subtract is A + ~B + 1; B is stored already inverted.
            a_d     = in_a;
            b_d     = in_sub ? ~in_b : in_b;
            carry_d = in_sub ? 1'b1 : in_carry;
            idx_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            sum_d[idx_q] = slice_s;
            carry_d      = slice_c;
            if (last) begin
               cout_d  = slice_c;
               ovf_d   = (a_q[NCHUNK-1][CHUNK_W-1] == b_q[NCHUNK-1][CHUNK_W-1])
                       & (slice_s[CHUNK_W-1] != a_q[NCHUNK-1][CHUNK_W-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign out_sum      = sum_q;
   assign out_carry    = cout_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder at WIDTH=64: vector table plus
// backpressure, busy-ignore and mid-operation reset sequences.
module tb_cla_seq_adder;

   localparam int W = 64;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_carry = 1'b0;
   logic         in_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         out_carry;
   logic         out_overflow;
   logic         busy;

   int tests = 0;
   int fails = 0;

   cla_seq_adder #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_carry     (in_carry),
      .in_sub       (in_sub),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one op and wait for out_valid; lat counts edges from the accept edge inclusive.
   task automatic issue(input vec_t v, output int lat);
      @(negedge clk);
      check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
      in_a = v.a; in_b = v.b; in_carry = v.cin; in_sub = v.sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
      check("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      issue(v, lat);
      check({tag, "_latency"}, 64'(lat), 64'd5);
      check({tag, "_sum"}, out_sum, v.sum);
      check({tag, "_carry"}, {63'd0, out_carry}, {63'd0, v.cout});
      check({tag, "_ovf"}, {63'd0, out_overflow}, {63'd0, v.ovf});
      handshake();
   endtask

   vec_t vecs[9];

   initial begin
      int lat;
      vec_t v;
      vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[1] = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[2] = '{64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0, 64'h0001_0000_0000_0001, 1'b0, 1'b0};
      vecs[6] = '{64'hA, 64'hA, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
      vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                  64'h2222_2222_2222_2211, 1'b0, 1'b0};
      vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_sum", out_sum, 64'd0);
      check("rst_carry", {63'd0, out_carry}, 64'd0);
      check("rst_ovf", {63'd0, out_overflow}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure with a competing request held high throughout RUN/DONE.
      @(negedge clk);
      in_a = 64'd3; in_b = 64'd4; in_carry = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 64'd100; in_b = 64'd100;
      check("bp_busy_run", {63'd0, busy}, 64'd1);
      check("bp_in_ready_run", {63'd0, in_ready}, 64'd0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", 64'(lat), 64'd5);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         check("bp_hold_sum", out_sum, 64'd7);
         check("bp_hold_carry", {63'd0, out_carry}, 64'd0);
         check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      handshake();
      check("bp_sum_after_hs", out_sum, 64'd7);
      v = '{64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0};
      run_vec(v, "bp_next");

      // Reset while RUN is on chunk index 2; chunks 0 and 1 already written.
      @(negedge clk);
      in_a = 64'h1111_1111_1111_1111; in_b = 64'h1111_1111_1111_1111;
      in_carry = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_partial_sum", {32'd0, out_sum[31:0]}, 64'h2222_2222);
      check("mid_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_sum", out_sum, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0};
      run_vec(v, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
